pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

- Central hazard controller for the five-stage IF/ID/EX/MEM/WB pipeline.
- Inspects the destination and control fields of the ID, EX, MEM and WB stages, plus a multi-cycle HI/LO (mult/div) tracker.
- Drives the PC write enable, the IF/ID hold and flush, the ID/EX bubble insertion (control word zeroed) and the EX operand forwarding selects.
- Sits beside the pipeline registers; it is the only block allowed to stall or flush them.

## Interface
Parameters:
- MD_CYCLES, 4: cycles a mult/div occupies HI/LO after issue; legal range 1–15.
- REG_W, 5: register-specifier width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  REG_W  source specifiers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt.
- id_md_op  in  1  the ID instruction is mult/div (writes HI/LO).
- id_hilo_read  in  1  the ID instruction is mfhi/mflo.
- ex_rd, mem_rd, wb_rd  in  REG_W  destination specifiers per stage.
- ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1  the stage writes the register file.
- ex_load_instr  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  a branch or jump resolved taken in EX.
- pc_enable  out  1  PC loads its next value.
- if_id_enable  out  1  IF/ID captures a new instruction.
- if_id_flush  out  1  IF/ID loads 32'b0.
- id_ex_bubble  out  1  ID/EX loads an all-zero control word.
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 01 EX/MEM result, 10 MEM/WB result, 11 WB write data.
- md_busy  out  1  HI/LO unit occupied.

## Operation
- Registered state: RUN and MD_WAIT, plus md_cnt, a ceil(log2(MD_CYCLES+1))-bit down counter. All outputs are combinational from state and inputs.
- Match rule: a stage matches rs when its rf_enable=1, its rd≠0 and rd==id_rs with id_use_rs=1. The same rule applies to rt.
- Priority, highest first:
  1. reset.
  2. ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_enable=1, if_id_enable=1.
  3. Stall: pc_enable=0, if_id_enable=0, id_ex_bubble=1.
  4. Normal: pc_enable=1, if_id_enable=1, flush=0, bubble=0.
- Stall conditions:
  - Load-use: ex_load_instr=1 and EX matches rs or rt.
  - HI/LO busy: state is MD_WAIT and (id_md_op or id_hilo_read).
- MD tracking:
  - In RUN, an id_md_op that is neither stalled nor flushed loads md_cnt=MD_CYCLES and moves the state to MD_WAIT.
  - In MD_WAIT, md_cnt decrements every cycle. Stalls and branches do not pause it.
  - When md_cnt==1, the next state is RUN with md_cnt=0.
  - md_busy = (state==MD_WAIT).
- An id_md_op present in the same cycle as ex_branch_taken is flushed and never starts.
- Forwarding per operand: EX match (non-load) → 01; else MEM match → 10; else WB match → 11; else 00. A specifier of 0 always gives 00.

## Timing
- Reset values, while reset=1 and on the cycle after:
  - State RUN, md_cnt=0.
  - During reset: pc_enable=0, if_id_enable=0, if_id_flush=0, id_ex_bubble=0, fwd_a=fwd_b=00, md_busy=0.
- Load-use stall lasts exactly one cycle. The next cycle the load is in MEM and the operand forwards via 10.
- MD timing, for an mult/div issued from ID in cycle T:
  - md_busy=1 in cycles T+1 … T+MD_CYCLES.
  - A dependent mfhi/mflo is stalled over those cycles and proceeds in T+MD_CYCLES+1.
- Back-to-back mult/div: the second one stalls until RUN, then issues normally.
- Reset asserted mid-MD_WAIT: state returns to RUN and md_cnt to 0 on that edge. No stall is carried over.
- Simultaneous branch and stall: the branch wins. The PC advances to the target and the ID instruction is flushed, not held.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding as above; stalls occur only for load-use and HI/LO busy.
- HAZARD_FORWARDING_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Any EX or MEM match (load or not) stalls.
  - WB matches do not stall; the register file is write-before-read.
  - MD logic is unchanged.

## Test plan
- Reset held for 3 cycles, with md_cnt previously at 2 → all outputs at their reset values. RUN is entered and md_busy=0 the cycle after release.
- Load-use: ex_load_instr=1, ex_rd=8, id_rs=8, id_use_rs=1 → exactly one cycle of pc_enable=0 and id_ex_bubble=1. The next cycle, with mem_rd=8, gives fwd_a=10.
- Forwarding priority, with the macro defined: ex_rd=mem_rd=wb_rd=5 (all rf_enable), id_rt=5 → fwd_b=01. Then id_rt=0 → fwd_b=00.
- MD with MD_CYCLES=4: mult issued at cycle 10, mfhi in ID at cycle 11 → stalled in cycles 11–14, md_busy high in 11–14, mfhi proceeds in cycle 15.
- Branch and load-use hazard in the same cycle, with id_md_op=1 → if_id_flush=1, pc_enable=1, md_busy stays 0.
- Macro undefined: non-load ex_rd=3, id_rs=3 → one stall cycle. Then mem_rd=3 → a second stall cycle; fwd_a stays 00 throughout.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard controller bundle; slave = controller, master = pipeline side
interface pipeline_hazard_ctrl_if #(parameter int REG_W = 5);
    logic [REG_W-1:0] i_id_rs, i_id_rt, i_ex_rd, i_mem_rd, i_wb_rd;
    logic i_id_use_rs, i_id_use_rt, i_id_md_op, i_id_hilo_read;
    logic i_ex_rf_enable, i_mem_rf_enable, i_wb_rf_enable;
    logic i_ex_load_instr, i_ex_branch_taken;
    logic o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble, o_md_busy;
    logic [1:0] o_fwd_a, o_fwd_b;
    modport slave (
        input  i_id_rs, i_id_rt, i_ex_rd, i_mem_rd, i_wb_rd,
        input  i_id_use_rs, i_id_use_rt, i_id_md_op, i_id_hilo_read,
        input  i_ex_rf_enable, i_mem_rf_enable, i_wb_rf_enable,
        input  i_ex_load_instr, i_ex_branch_taken,
        output o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble, o_md_busy,
        output o_fwd_a, o_fwd_b
    );
    modport master (
        output i_id_rs, i_id_rt, i_ex_rd, i_mem_rd, i_wb_rd,
        output i_id_use_rs, i_id_use_rt, i_id_md_op, i_id_hilo_read,
        output i_ex_rf_enable, i_mem_rf_enable, i_wb_rf_enable,
        output i_ex_load_instr, i_ex_branch_taken,
        input  o_pc_enable, o_if_id_enable, o_if_id_flush, o_id_ex_bubble, o_md_busy,
        input  o_fwd_a, o_fwd_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for a 5-stage pipeline with HI/LO tracking
// Ports: clk, reset (sync, active-high), hz (pipeline_hazard_ctrl_if.slave: stage fields in, pipeline controls out)
// Optional macro HAZARD_FORWARDING_EN: enables EX operand forwarding; otherwise EX/MEM matches stall
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int REG_W     = 5
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int CW = $clog2(MD_CYCLES + 1);
    typedef enum logic {RUN, MD_WAIT} state_t;
    state_t r_state;
    logic [CW-1:0] r_md_cnt;
    function automatic logic f_match(input logic en, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src, input logic use_src);
        return en && (rd != '0) && (rd == src) && use_src;
    endfunction
    logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_hilo_stall, w_stall, w_md_issue;
    logic [1:0] w_fwd_a, w_fwd_b;
    assign w_ex_a  = f_match(hz.i_ex_rf_enable,  hz.i_ex_rd,  hz.i_id_rs, hz.i_id_use_rs);
    assign w_ex_b  = f_match(hz.i_ex_rf_enable,  hz.i_ex_rd,  hz.i_id_rt, hz.i_id_use_rt);
    assign w_mem_a = f_match(hz.i_mem_rf_enable, hz.i_mem_rd, hz.i_id_rs, hz.i_id_use_rs);
    assign w_mem_b = f_match(hz.i_mem_rf_enable, hz.i_mem_rd, hz.i_id_rs == hz.i_id_rs ? hz.i_id_rt : hz.i_id_rt, hz.i_id_use_rt);
    assign w_hilo_stall = (r_state == MD_WAIT) && (hz.i_id_md_op || hz.i_id_hilo_read);
`ifdef HAZARD_FORWARDING_EN
    logic w_wb_a, w_wb_b;
    assign w_wb_a = f_match(hz.i_wb_rf_enable, hz.i_wb_rd, hz.i_id_rs, hz.i_id_use_rs);
    assign w_wb_b = f_match(hz.i_wb_rf_enable, hz.i_wb_rd, hz.i_id_rt, hz.i_id_use_rt);
    assign w_stall = (hz.i_ex_load_instr && (w_ex_a || w_ex_b)) || w_hilo_stall;
    // a load's EX result is not ready yet, so it is skipped and older stages are considered
    assign w_fwd_a = reset ? 2'b00 : (w_ex_a && !hz.i_ex_load_instr) ? 2'b01 : w_mem_a ? 2'b10 : w_wb_a ? 2'b11 : 2'b00;
    assign w_fwd_b = reset ? 2'b00 : (w_ex_b && !hz.i_ex_load_instr) ? 2'b01 : w_mem_b ? 2'b10 : w_wb_b ? 2'b11 : 2'b00;
`else
    logic w_unused;
    // WB needs no action: the register file writes before it is read
    assign w_unused = ^{hz.i_ex_load_instr, hz.i_wb_rd, hz.i_wb_rf_enable};
    assign w_stall = w_ex_a || w_ex_b || w_mem_a || w_mem_b || w_hilo_stall;
    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;
`endif
    // a flushed or stalled mult/div never occupies HI/LO
    assign w_md_issue = hz.i_id_md_op && !w_stall && !hz.i_ex_branch_taken;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else if (r_state == RUN) begin
            if (w_md_issue) begin
                r_state  <= MD_WAIT;
                r_md_cnt <= CW'(MD_CYCLES);
            end
        end else begin
            r_state  <= (r_md_cnt == CW'(1)) ? RUN : MD_WAIT;
            r_md_cnt <= r_md_cnt - CW'(1);
        end
    end
    // branch outranks stall: the PC moves to the target and ID is flushed rather than held
    assign hz.o_pc_enable    = !reset && (hz.i_ex_branch_taken || !w_stall);
    assign hz.o_if_id_enable = !reset && (hz.i_ex_branch_taken || !w_stall);
    assign hz.o_if_id_flush  = !reset && hz.i_ex_branch_taken;
    assign hz.o_id_ex_bubble = !reset && (hz.i_ex_branch_taken || w_stall);
    assign hz.o_md_busy      = !reset && (r_state == MD_WAIT);
    assign hz.o_fwd_a        = w_fwd_a;
    assign hz.o_fwd_b        = w_fwd_b;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int compared = 0;
    int mismatched = 0;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif
    typedef struct {
        string tag;
        logic [8:0] v;
    } exp_t;
    exp_t sb[$];
    pipeline_hazard_ctrl_if #(.REG_W(5)) hif ();
    pipeline_hazard_ctrl #(.MD_CYCLES(4), .REG_W(5)) dut (.clk(clk), .reset(reset), .hz(hif.slave));
    always #5 clk = ~clk;
    function automatic logic [8:0] e(input logic stl, input logic [1:0] fa, input logic [1:0] fb, input logic busy);
        return stl ? {4'b0001, fa, fb, busy} : {4'b1100, fa, fb, busy};
    endfunction
    task automatic clr();
        hif.i_id_rs = '0; hif.i_id_rt = '0; hif.i_ex_rd = '0; hif.i_mem_rd = '0; hif.i_wb_rd = '0;
        hif.i_id_use_rs = 0; hif.i_id_use_rt = 0; hif.i_id_md_op = 0; hif.i_id_hilo_read = 0;
        hif.i_ex_rf_enable = 0; hif.i_mem_rf_enable = 0; hif.i_wb_rf_enable = 0;
        hif.i_ex_load_instr = 0; hif.i_ex_branch_taken = 0;
    endtask
    task automatic cyc(input string tag, input logic [8:0] v);
        exp_t x;
        logic [8:0] obs;
        sb.push_back('{tag, v});
        @(negedge clk);
        x = sb.pop_front();
        obs = {hif.o_pc_enable, hif.o_if_id_enable, hif.o_if_id_flush, hif.o_id_ex_bubble,
               hif.o_fwd_a, hif.o_fwd_b, hif.o_md_busy};
        compared++;
        assert (obs === x.v) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.v);
        end
        @(posedge clk);
        #1;
    endtask
    initial begin
        clr();
        reset = 1;
        cyc("reset_init", 9'b0);
        reset = 0;
        cyc("idle", e(0, 0, 0, 0));
        // mult, then reset while md_cnt is 2
        hif.i_id_md_op = 1;
        cyc("mult_issue", e(0, 0, 0, 0));
        hif.i_id_md_op = 0;
        cyc("md_busy_c4", e(0, 0, 0, 1));
        cyc("md_busy_c3", e(0, 0, 0, 1));
        reset = 1;
        hif.i_id_hilo_read = 1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", 9'b0);
        reset = 0;
        cyc("reset_release", e(0, 0, 0, 0));
        cyc("no_stall_after_rst", e(0, 0, 0, 0));
        clr();
        // load-use
        hif.i_ex_load_instr = 1; hif.i_ex_rd = 8; hif.i_ex_rf_enable = 1;
        hif.i_id_rs = 8; hif.i_id_use_rs = 1;
        cyc("load_use_stall", e(1, 0, 0, 0));
        hif.i_ex_load_instr = 0; hif.i_ex_rd = 0; hif.i_ex_rf_enable = 0;
        hif.i_mem_rd = 8; hif.i_mem_rf_enable = 1;
        cyc("load_use_after", FW ? e(0, 2'b10, 0, 0) : e(1, 0, 0, 0));
        clr();
        // forwarding priority on rt
        hif.i_ex_rd = 5; hif.i_mem_rd = 5; hif.i_wb_rd = 5;
        hif.i_ex_rf_enable = 1; hif.i_mem_rf_enable = 1; hif.i_wb_rf_enable = 1;
        hif.i_id_rt = 5; hif.i_id_use_rt = 1;
        cyc("fwd_b_ex", FW ? e(0, 0, 2'b01, 0) : e(1, 0, 0, 0));
        hif.i_ex_rf_enable = 0;
        cyc("fwd_b_mem", FW ? e(0, 0, 2'b10, 0) : e(1, 0, 0, 0));
        hif.i_mem_rf_enable = 0;
        cyc("fwd_b_wb", FW ? e(0, 0, 2'b11, 0) : e(0, 0, 0, 0));
        hif.i_ex_rf_enable = 1; hif.i_mem_rf_enable = 1; hif.i_id_rt = 0;
        cyc("fwd_b_zero", e(0, 0, 0, 0));
        hif.i_id_rt = 5; hif.i_id_use_rt = 0;
        cyc("fwd_b_unused", e(0, 0, 0, 0));
        clr();
        hif.i_mem_rd = 6; hif.i_mem_rf_enable = 1; hif.i_id_rs = 6; hif.i_id_use_rs = 1;
        hif.i_wb_rd = 7; hif.i_wb_rf_enable = 1; hif.i_id_rt = 7; hif.i_id_use_rt = 1;
        cyc("fwd_ab_mix", FW ? e(0, 2'b10, 2'b11, 0) : e(1, 0, 0, 0));
        clr();
        // mult then dependent mfhi
        hif.i_id_md_op = 1;
        cyc("md_issue_T", e(0, 0, 0, 0));
        hif.i_id_md_op = 0; hif.i_id_hilo_read = 1;
        for (int i = 1; i <= 4; i++) cyc($sformatf("mfhi_stall_T%0d", i), e(1, 0, 0, 1));
        cyc("mfhi_proceed", e(0, 0, 0, 0));
        clr();
        // back-to-back mult/div
        hif.i_id_md_op = 1;
        cyc("md1_issue", e(0, 0, 0, 0));
        for (int i = 1; i <= 4; i++) cyc($sformatf("md2_stall_%0d", i), e(1, 0, 0, 1));
        cyc("md2_issue", e(0, 0, 0, 0));
        hif.i_id_md_op = 0;
        hif.i_ex_branch_taken = 1;
        cyc("md2_busy_branch", {4'b1111, 4'b0000, 1'b1});
        hif.i_ex_branch_taken = 0;
        for (int i = 2; i <= 4; i++) cyc($sformatf("md2_busy_%0d", i), e(0, 0, 0, 1));
        cyc("md2_done", e(0, 0, 0, 0));
        // branch wins over load-use, flushed mult never starts
        hif.i_ex_branch_taken = 1; hif.i_ex_load_instr = 1; hif.i_ex_rd = 8; hif.i_ex_rf_enable = 1;
        hif.i_id_rs = 8; hif.i_id_use_rs = 1; hif.i_id_md_op = 1;
        cyc("branch_vs_stall", {4'b1111, 4'b0000, 1'b0});
        clr();
        cyc("flushed_md_idle", e(0, 0, 0, 0));
        // non-load EX then MEM dependency
        hif.i_ex_rd = 3; hif.i_ex_rf_enable = 1; hif.i_id_rs = 3; hif.i_id_use_rs = 1;
        cyc("nonload_ex", FW ? e(0, 2'b01, 0, 0) : e(1, 0, 0, 0));
        hif.i_ex_rd = 0; hif.i_ex_rf_enable = 0; hif.i_mem_rd = 3; hif.i_mem_rf_enable = 1;
        cyc("nonload_mem", FW ? e(0, 2'b10, 0, 0) : e(1, 0, 0, 0));
        clr();
        cyc("final_idle", e(0, 0, 0, 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
